// File: rtl/cmd_echo_if.sv
// Command bus and upload handshake between command_processor and a handler.
// master = command_processor / upload path, slave = handler.
interface cmd_echo_if;
  logic [7:0]  cmd_type_in;
  logic [15:0] cmd_length_in;
  logic [7:0]  cmd_data_in;
  logic [15:0] cmd_data_index_in;
  logic        cmd_start_in;
  logic        cmd_data_valid_in;
  logic        cmd_done_in;
  logic        cmd_ready_out;
  logic        upload_req_out;
  logic [7:0]  upload_data_out;
  logic [7:0]  upload_source_out;
  logic        upload_valid_out;
  logic        upload_ready_in;

  modport master (
    output cmd_type_in, cmd_length_in, cmd_data_in,
    output cmd_data_index_in, cmd_start_in,
    output cmd_data_valid_in, cmd_done_in,
    input  cmd_ready_out,
    input  upload_req_out, upload_data_out,
    input  upload_source_out, upload_valid_out,
    output upload_ready_in
  );

  modport slave (
    input  cmd_type_in, cmd_length_in, cmd_data_in,
    input  cmd_data_index_in, cmd_start_in,
    input  cmd_data_valid_in, cmd_done_in,
    output cmd_ready_out,
    output upload_req_out, upload_data_out,
    output upload_source_out, upload_valid_out,
    input  upload_ready_in
  );
endinterface

// File: rtl/cmd_echo_handler.sv
// ECHO command handler: buffers an ECHO payload and returns it on the
// upload path; also serves the zero-length RESET command.
module cmd_echo_handler #(
  parameter logic [7:0] CMD_ECHO      = 8'h30,
  parameter logic [7:0] CMD_RESET     = 8'h20,
  parameter logic [7:0] UPLOAD_SOURCE = 8'h30,
  parameter int         BUF_AW        = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  cmd_echo_if.slave  bus,
  output logic       overflow_out,
  output logic [7:0] echo_count_out
);
  localparam int DEPTH = 2 ** BUF_AW;
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, UPLOAD} state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [BUF_AW:0]   cnt_q, cnt_d;
  logic [BUF_AW:0]   ptr_q, ptr_d;
  logic [BUF_AW-1:0] ptr_nx;
  logic              req_q, req_d;
  logic              vld_q, vld_d;
  logic              rdy_q, rdy_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        dat_q, dat_d;
  logic [7:0]        src_q, src_d;
  logic [7:0]        ecnt_q, ecnt_d;
  logic [7:0]        mem [DEPTH];

  logic       in_rng, wr_en, is_echo, is_rst, xfer;
  logic [7:0] first_b;

  assign in_rng  = (bus.cmd_data_index_in >> BUF_AW) == '0;
  assign wr_en   = (state_q == RECV) && !bus.cmd_start_in
                 && bus.cmd_data_valid_in && in_rng;
  assign is_echo = bus.cmd_type_in == CMD_ECHO;
  assign is_rst  = bus.cmd_type_in == CMD_RESET;
  assign xfer    = vld_q && bus.upload_ready_in;
  assign ptr_nx  = ptr_q[BUF_AW-1:0] + 1'b1;

  // byte 0 may be written on the same edge the upload starts
  assign first_b = (wr_en && bus.cmd_data_index_in[BUF_AW-1:0] == '0)
                 ? bus.cmd_data_in : mem[0];

  always_ff @(posedge clk) begin
    if (wr_en) mem[bus.cmd_data_index_in[BUF_AW-1:0]] <= bus.cmd_data_in;
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    req_d   = req_q;
    vld_d   = vld_q;
    dat_d   = dat_q;
    src_d   = src_q;
    ovf_d   = ovf_q;
    ecnt_d  = ecnt_q;
    unique case (state_q)
      IDLE, RECV: begin
        if (bus.cmd_start_in) begin
          unique case (1'b1)
            is_rst: begin
              ovf_d   = 1'b0;
              ecnt_d  = '0;
              state_d = IDLE;
            end
            is_echo: begin
              if (bus.cmd_done_in) begin
                ecnt_d  = ecnt_q + 8'd1;
                state_d = IDLE;
              end else begin
                len_d   = bus.cmd_length_in;
                state_d = RECV;
              end
            end
            default: state_d = IDLE;
          endcase
        end else if (state_q == RECV) begin
          if (bus.cmd_data_valid_in && !in_rng) ovf_d = 1'b1;
          if (bus.cmd_done_in) begin
            ecnt_d = ecnt_q + 8'd1;
            cnt_d  = (len_q > DEPTH16) ? DEPTH16[BUF_AW:0]
                                       : len_q[BUF_AW:0];
            if (len_q == '0) begin
              state_d = IDLE;
            end else begin
              state_d = UPLOAD;
              ptr_d   = '0;
              req_d   = 1'b1;
              vld_d   = 1'b1;
              src_d   = UPLOAD_SOURCE;
              dat_d   = first_b;
            end
          end
        end
      end
      UPLOAD: begin
        if (xfer) begin
          if (ptr_q == cnt_q - 1'b1) begin
            state_d = IDLE;
            req_d   = 1'b0;
            vld_d   = 1'b0;
            src_d   = '0;
            dat_d   = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
            dat_d = mem[ptr_nx];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = state_d != UPLOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
      ovf_q   <= 1'b0;
      dat_q   <= '0;
      src_q   <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
      ovf_q   <= ovf_d;
      dat_q   <= dat_d;
      src_q   <= src_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign bus.cmd_ready_out     = rdy_q;
  assign bus.upload_req_out    = req_q;
  assign bus.upload_valid_out  = vld_q;
  assign bus.upload_data_out   = dat_q;
  assign bus.upload_source_out = src_q;
  assign overflow_out          = ovf_q;
  assign echo_count_out        = ecnt_q;
endmodule

// File: doc/cmd_echo_handler.md
Name: cmd_echo_handler

Overview:
- Command-bus handler on the handler side of command_processor.
- Consumes the command bus. Captures the payload of ECHO commands into a local byte buffer, then returns it to the host through the upload request/valid/ready interface, tagged with a source ID.
- Also serves the zero-length RESET command, whose cmd_start and cmd_done arrive in the same cycle. The block doubles as the reference handler for command-bus and upload-path bring-up.

Parameters:
- CMD_ECHO, 8'h30, command type captured and echoed
- CMD_RESET, 8'h20, zero-length command that clears handler state
- UPLOAD_SOURCE, 8'h30, value driven on upload_source_out
- BUF_AW, 6, buffer address width; depth = 2**BUF_AW bytes (64)

Ports:
- clk  in  1  system clock (60 MHz)
- rst_n  in  1  reset, asynchronous, active-low
- cmd_type_in  in  8  command type; valid with cmd_start_in
- cmd_length_in  in  16  payload length; valid with cmd_start_in
- cmd_data_in  in  8  payload byte
- cmd_data_index_in  in  16  byte index of cmd_data_in
- cmd_start_in  in  1  one-cycle command start strobe
- cmd_data_valid_in  in  1  payload byte strobe
- cmd_done_in  in  1  one-cycle command end strobe; may coincide with cmd_start_in
- cmd_ready_out  out  1  handler can accept a new command
- upload_req_out  out  1  requests the upload path
- upload_data_out  out  8  upload byte
- upload_source_out  out  8  source tag; UPLOAD_SOURCE whenever upload_req_out=1, else 0
- upload_valid_out  out  1  upload_data_out valid
- upload_ready_in  in  1  upload path accepts the byte
- overflow_out  out  1  sticky: an ECHO payload exceeded buffer depth
- echo_count_out  out  8  completed ECHO commands; wraps 255->0

Behaviour:
Reset (all outputs registered):
- All outputs reset to 0.
- State resets to IDLE.
- cmd_ready_out rises on the first clock edge after rst_n deasserts.
- Assertion of rst_n mid-RECV or mid-UPLOAD aborts immediately; no partial upload resumes.

State IDLE (cmd_ready_out=1):
- cmd_start_in with cmd_type_in=CMD_RESET:
  - Clears overflow_out and echo_count_out at the next edge.
  - Stays in IDLE.
  - cmd_done_in in the same cycle is expected and consumed.
- cmd_start_in with cmd_type_in=CMD_ECHO and cmd_done_in=1 in the same cycle (zero-length):
  - echo_count_out += 1.
  - No upload; stays in IDLE.
- cmd_start_in with cmd_type_in=CMD_ECHO and cmd_done_in=0:
  - Latch cmd_length_in.
  - Clear the write count; go to RECV.
- Any other type: ignored, including its data and done strobes.

State RECV (cmd_ready_out=1):
- On cmd_data_valid_in:
  - If cmd_data_index_in < 2**BUF_AW: write the byte to buf[index].
  - Otherwise drop the byte and set overflow_out.
- On cmd_done_in:
  - cnt = min(latched length, 2**BUF_AW).
  - echo_count_out += 1.
  - If cnt=0, go to IDLE; else rd_ptr=0, go to UPLOAD.
- A data byte and cmd_done_in in the same cycle: the byte is written first, then the done is processed.
- cmd_start_in in RECV (protocol violation): restart capture with the new command per the IDLE rules.

State UPLOAD (cmd_ready_out=0):
- Entry edge: upload_req_out=1, upload_valid_out=1, upload_data_out=buf[0].
- Byte transfer occurs on a cycle where upload_valid_out && upload_ready_in.
- upload_data_out and upload_valid_out are held stable while upload_ready_in=0.
- After each transfer, the next byte is presented on the following edge; back-to-back transfers at 1 byte/cycle.
- After transfer of byte cnt-1: upload_req_out, upload_valid_out and upload_source_out drop at the next edge; go to IDLE.
- cmd_start_in and cmd_data_valid_in are ignored in UPLOAD; command_processor withholds commands while cmd_ready_out=0.

Latency and counters:
- Latency from cmd_done_in to first upload_valid_out: 1 cycle.
- echo_count_out and overflow_out update one edge after the triggering strobe.

Test Plan:
1. RESET single cycle: cmd_start_in, cmd_done_in and type 8'h20 asserted together for one cycle, after echo_count_out=3 and overflow_out=1 -> both read 0 next cycle; cmd_ready_out stays 1; upload_req_out never asserts.
2. Basic echo: ECHO len=4, bytes 8'hA1,A2,A3,A4, upload_ready_in tied 1 -> 4 consecutive valid cycles carrying A1..A4 with upload_source_out=8'h30; req drops after the 4th; echo_count_out=1.
3. Backpressure: echo len=3 with upload_ready_in low for 5 cycles at each byte -> upload_data_out held constant while stalled; order preserved; exactly 3 transfers.
4. Overflow: ECHO len=70, indices 0..69 -> exactly 64 bytes uploaded (indices 0..63); overflow_out=1; cmd_ready_out low throughout upload.
5. Zero-length ECHO and foreign command: ECHO len=0 with start+done in the same cycle -> echo_count_out +1, no upload; type 8'h40 len=5 with data -> no buffer writes, no count change.
6. Reset mid-upload: rst_n pulled low during byte 2 of an 8-byte upload -> all outputs 0 immediately; after release cmd_ready_out=1 next edge; a fresh ECHO len=2 uploads correctly.
